// File: rtl/tc_sram_banked_pkg.sv
// Shared types and helpers for the banked scratchpad SRAM model:
// address-to-bank mapping, response-pipeline entries and reset-content selectors.
package tc_sram_banked_pkg;

    localparam string SimInitZeros  = "zeros";
    localparam string SimInitOnes   = "ones";
    localparam string SimInitRandom = "random";
    localparam string SimInitNone   = "none";

    // Widest word the response pipeline can carry.
    localparam int unsigned RespDataMax = 64;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic                   oor;
        logic [RespDataMax-1:0] data;
    } resp_entry_t;

    // Words are interleaved across banks, so the low address bits pick the bank.
    function automatic int unsigned bank_sel(input int unsigned addr, input int unsigned bankBits);
        return (bankBits == 0) ? 32'd0 : (addr & ((32'd1 << bankBits) - 32'd1));
    endfunction

    function automatic int unsigned row_sel(input int unsigned addr, input int unsigned bankBits);
        return addr >> bankBits;
    endfunction

    function automatic logic [RespDataMax-1:0] init_word(input int unsigned bank, input int unsigned row);
        logic [31:0] h;
        h = (bank * 32'd65536 + row + 32'd1) * 32'h9E3779B9;
        return {h ^ 32'h5A5A_1234, h};
    endfunction

endpackage

// File: rtl/tc_sram_banked_rr_arb.sv
// Round-robin arbiter for one bank: a one-hot grant that starts searching at the
// pointer index, with the pointer moving past the winner whenever a grant is given.
module tc_sram_banked_rr_arb #(
    parameter int unsigned NumReq = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrW-1:0] r_ptr;
    logic [PtrW-1:0] w_winner;
    logic            w_found;

    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        gnt_o    = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(r_ptr) + k) % NumReq;
            if (!w_found && req_i[idx]) begin
                w_found  = 1'b1;
                w_winner = PtrW'(idx);
            end
        end
        if (w_found) begin
            gnt_o[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_winner == PtrW'(NumReq - 1)) ? '0 : w_winner + PtrW'(1);
        end
    end

endmodule

// File: rtl/tc_sram_banked.sv
// Multi-port, word-interleaved banked SRAM model with per-bank round-robin grants
// and fixed-latency in-order responses. Optional lane parity: TC_SRAM_BANKED_PARITY_EN.
module tc_sram_banked
    import tc_sram_banked_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned NumBanks  = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned Latency   = 1,
    parameter string       SimInit   = "none",
    localparam int unsigned AddrWidth = (NumWords == 1) ? 1 : $clog2(NumWords),
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumPorts-1:0]                  req_i,
    output logic [NumPorts-1:0]                  gnt_o,
    input  logic [NumPorts-1:0]                  we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
    output logic [NumPorts-1:0]                  rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
`ifdef TC_SRAM_BANKED_PARITY_EN
    ,
    output logic [NumPorts-1:0]                  rerr_o
`endif
);

    localparam int unsigned BankBits = (NumBanks > 1) ? $clog2(NumBanks) : 0;
    localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;
    localparam int unsigned NumRows  = NumWords / NumBanks;
    localparam int unsigned RowW     = (NumRows > 1) ? $clog2(NumRows) : 1;

    logic [NumPorts-1:0][BankW-1:0]     w_bank;
    logic [NumPorts-1:0][RowW-1:0]      w_row;
    logic [NumPorts-1:0]                w_oor;
    logic [NumBanks-1:0][NumPorts-1:0]  w_bankReq;
    logic [NumBanks-1:0][NumPorts-1:0]  w_bankGnt;
    logic [NumPorts-1:0]                w_gnt;
    logic [NumPorts-1:0][DataWidth-1:0] w_rd;
    logic                               w_unusedData;

    logic [DataWidth-1:0] r_mem  [NumBanks][NumRows];
    resp_entry_t          r_pipe [NumPorts][Latency];

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_oor[p]  = 32'(addr_i[p]) >= NumWords;
            w_bank[p] = BankW'(bank_sel(32'(addr_i[p]), BankBits));
            w_row[p]  = RowW'(row_sel(32'(addr_i[p]), BankBits));
        end
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                w_bankReq[b][p] = req_i[p] && rst_ni && (w_bank[p] == BankW'(b));
            end
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        tc_sram_banked_rr_arb #(.NumReq(NumPorts)) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (w_bankReq[b]),
            .gnt_o  (w_bankGnt[b])
        );
    end

    // A port is served by at most one bank, so OR-ing the bank grants is one-hot per port.
    always_comb begin
        w_gnt = '0;
        for (int b = 0; b < NumBanks; b++) begin
            w_gnt = w_gnt | w_bankGnt[b];
        end
        for (int p = 0; p < NumPorts; p++) begin
            w_rd[p] = '0;
            if (!w_oor[p]) begin
                w_rd[p] = r_mem[w_bank[p]][w_row[p]];
            end
        end
    end

    assign gnt_o = w_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumBanks; b++) begin
                for (int r = 0; r < NumRows; r++) begin
                    if (SimInit == SimInitZeros) begin
                        r_mem[b][r] <= '0;
                    end else if (SimInit == SimInitOnes) begin
                        r_mem[b][r] <= '1;
                    end else if (SimInit == SimInitRandom) begin
                        r_mem[b][r] <= DataWidth'(init_word(b, r));
                    end
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (w_gnt[p] && we_i[p] && !w_oor[p]) begin
                    for (int j = 0; j < DataWidth; j++) begin
                        if (be_i[p][j / ByteWidth]) begin
                            r_mem[w_bank[p]][w_row[p]][j] <= wdata_i[p][j];
                        end
                    end
                end
            end
        end
    end

`ifdef TC_SRAM_BANKED_PARITY_EN
    logic [BeWidth-1:0] r_par      [NumBanks][NumRows];
    logic [Latency-1:0] r_errPipe  [NumPorts];
    logic [NumPorts-1:0] w_rdErr;

    function automatic logic [BeWidth-1:0] lane_parity(input logic [DataWidth-1:0] word);
        logic [BeWidth-1:0] par;
        par = '0;
        for (int j = 0; j < DataWidth; j++) begin
            par[j / ByteWidth] = par[j / ByteWidth] ^ word[j];
        end
        return par;
    endfunction

    // Plain always so the bench hook below may also flip stored parity bits.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumBanks; b++) begin
                for (int r = 0; r < NumRows; r++) begin
                    if (SimInit == SimInitZeros) begin
                        r_par[b][r] <= '0;
                    end else if (SimInit == SimInitOnes) begin
                        r_par[b][r] <= lane_parity('1);
                    end else if (SimInit == SimInitRandom) begin
                        r_par[b][r] <= lane_parity(DataWidth'(init_word(b, r)));
                    end
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (w_gnt[p] && we_i[p] && !w_oor[p]) begin
                    for (int l = 0; l < BeWidth; l++) begin
                        if (be_i[p][l]) begin
                            r_par[w_bank[p]][w_row[p]][l] <= lane_parity(wdata_i[p])[l];
                        end
                    end
                end
            end
        end
    end

    task automatic inject_parity_flip(input int unsigned bank, input int unsigned row, input int unsigned lane);
        r_par[bank][row][lane] = ~r_par[bank][row][lane];
    endtask

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_rdErr[p] = w_oor[p];
            if (!w_oor[p]) begin
                w_rdErr[p] = |(lane_parity(w_rd[p]) ^ r_par[w_bank[p]][w_row[p]]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) begin
                r_errPipe[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                r_errPipe[p] <= Latency'({r_errPipe[p], w_gnt[p] && !we_i[p] && w_rdErr[p]});
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            rerr_o[p] = r_pipe[p][Latency-1].valid && r_errPipe[p][Latency-1];
        end
    end
`endif

    // Read data is captured at the grant edge; writes carry zero data through the pipe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) begin
                for (int s = 0; s < Latency; s++) begin
                    r_pipe[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                r_pipe[p][0] <= '0;
                if (w_gnt[p]) begin
                    r_pipe[p][0].valid    <= 1'b1;
                    r_pipe[p][0].is_write <= we_i[p];
                    r_pipe[p][0].oor      <= w_oor[p];
                    r_pipe[p][0].data     <= we_i[p] ? '0 : RespDataMax'(w_rd[p]);
                end
                for (int s = 1; s < Latency; s++) begin
                    r_pipe[p][s] <= r_pipe[p][s-1];
                end
            end
        end
    end

    always_comb begin
        w_unusedData = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            rvalid_o[p] = r_pipe[p][Latency-1].valid;
            rdata_o[p]  = '0;
            if (r_pipe[p][Latency-1].valid && !r_pipe[p][Latency-1].is_write && !r_pipe[p][Latency-1].oor) begin
                rdata_o[p] = r_pipe[p][Latency-1].data[DataWidth-1:0];
            end
            w_unusedData = w_unusedData ^ (^r_pipe[p][Latency-1].data);
        end
    end

    always @(posedge clk_i) begin
        assert ((NumBanks & (NumBanks - 1)) == 0 && NumBanks >= 1 && (NumWords % NumBanks) == 0
                && Latency >= 1 && NumPorts >= 1 && DataWidth <= RespDataMax)
            else $error("tc_sram_banked: illegal parameter combination");
        for (int p = 0; p < NumPorts; p++) begin
            if (rst_ni && w_gnt[p] && w_oor[p]) begin
                $warning("tc_sram_banked: port %0d out-of-range address %0d", p, addr_i[p]);
            end
        end
    end

endmodule
